// File: rtl/encoder_pulse_gen.sv
// rtl/encoder_pulse_gen.sv - register-programmed encoder edge generator
//
// Emits COUNT edges on pulse_out, one every PERIOD clocks, while CTRL.EN is set.
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   rden       read enable; dout is 0 when low
//   din[31:0]  write data
//   dout[31:0] combinational read of the addressed register
//   addr[2:0]  register address: 0 COUNT, 1 CTRL, 2 PERIOD, 3 TOTAL, 4-7 unused
//   wren       write strobe, applied on the rising edge
//   pulse_out  generated waveform; every toggle is one encoder edge
module encoder_pulse_gen #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rden,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [2:0]  addr,
    input  logic        wren,
    output logic        pulse_out
);

    localparam logic [2:0] ADDR_COUNT  = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_TOTAL  = 3'd3;

    logic [31:0] count_q,  count_d;
    logic [31:0] period_q, period_d;
    logic [31:0] total_q,  total_d;
    logic [31:0] div_q,    div_d;
    logic        en_q,     en_d;
    logic        pulse_q,  pulse_d;

    logic [31:0] p_eff;
    logic        active;
    logic        fire;
    logic        busy;
    logic        wr_count, wr_ctrl, wr_period, wr_total;

    assign wr_count  = wren && (addr == ADDR_COUNT);
    assign wr_ctrl   = wren && (addr == ADDR_CTRL);
    assign wr_period = wren && (addr == ADDR_PERIOD);
    assign wr_total  = wren && (addr == ADDR_TOTAL);

    // PERIOD of 0 is treated as 1 so the generator can never stall mid-burst.
    assign p_eff  = (period_q == 32'd0) ? 32'd1 : period_q;
    assign busy   = en_q && (count_q != 32'd0);
    assign active = busy;
    // A COUNT write in the same cycle pre-empts the edge entirely.
    assign fire   = active && (div_q >= (p_eff - 32'd1)) && !wr_count;

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        total_d  = total_q;
        div_d    = div_q;
        en_d     = en_q;
        pulse_d  = pulse_q;

        if (fire) begin
            pulse_d = ~pulse_q;
            count_d = count_q - 32'd1;
            total_d = total_q + 32'd1;
            div_d   = 32'd0;
        end else if (active) begin
            div_d = div_q + 32'd1;
        end else if (count_q == 32'd0) begin
            div_d = 32'd0;
        end

        if (wr_count) begin
            count_d = din;
            div_d   = 32'd0;
        end
        if (wr_ctrl) begin
            en_d = din[0];
        end
        if (wr_period) begin
            period_d = din;
        end
        // A clear beats an edge landing in the same cycle.
        if (wr_total) begin
            total_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 32'd0;
            period_q <= DEFAULT_PERIOD;
            total_q  <= 32'd0;
            div_q    <= 32'd0;
            en_q     <= 1'b1;
            pulse_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            total_q  <= total_d;
            div_q    <= div_d;
            en_q     <= en_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        dout = 32'd0;
        if (rden) begin
            case (addr)
                ADDR_COUNT:  dout = count_q;
                ADDR_CTRL:   dout = {30'd0, busy, en_q};
                ADDR_PERIOD: dout = period_q;
                ADDR_TOTAL:  dout = total_q;
                default:     dout = 32'd0;
            endcase
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_encoder_pulse_gen.sv
// tb/tb_encoder_pulse_gen.sv - self-checking bench for encoder_pulse_gen
module tb_encoder_pulse_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        rden;
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  addr;
    logic        wren;
    logic        pulse_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges owed, clocks waited toward the next edge.
    logic [31:0] m_left;
    logic [31:0] m_period;
    logic [31:0] m_total;
    logic        m_en;
    logic        m_level;
    longint      m_wait;

    // Loopback edge counter watching pulse_out.
    int          edges;
    logic        prev_pulse;

    encoder_pulse_gen #(.DEFAULT_PERIOD(32'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rden      (rden),
        .din       (din),
        .dout      (dout),
        .addr      (addr),
        .wren      (wren),
        .pulse_out (pulse_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left   = 32'd0;
        m_period = 32'd4;
        m_total  = 32'd0;
        m_en     = 1'b1;
        m_level  = 1'b0;
        m_wait   = 0;
    endtask

    // One clock of the generator: while enabled with edges owed, wait
    // max(PERIOD,1) clocks per edge. A COUNT write restarts the wait and
    // suppresses any edge that would land in the same clock.
    task automatic model_step(input logic w, input logic [2:0] a, input logic [31:0] d);
        longint p;
        logic   edge_now;
        p        = (m_period == 0) ? 1 : longint'(m_period);
        edge_now = 1'b0;
        if (m_en && m_left != 0) begin
            m_wait = m_wait + 1;
            if (m_wait >= p) begin
                edge_now = 1'b1;
                m_wait   = 0;
            end
        end
        if (w && a == 3'd0) begin
            m_left   = d;
            m_wait   = 0;
            edge_now = 1'b0;
        end
        if (edge_now) begin
            m_level = ~m_level;
            m_left  = m_left - 1;
            m_total = m_total + 1;
        end
        if (w && a == 3'd1) m_en = d[0];
        if (w && a == 3'd2) m_period = d;
        if (w && a == 3'd3) m_total = 32'd0;
    endtask

    task automatic tick(input logic w, input logic [2:0] a, input logic [31:0] d);
        wren = w;
        addr = a;
        din  = d;
        rden = 1'b0;
        model_step(w, a, d);
        @(posedge clk);
        #1;
        wren = 1'b0;
        din  = 32'd0;
        if (pulse_out !== prev_pulse) edges++;
        prev_pulse = pulse_out;
        check("pulse", {31'd0, pulse_out}, {31'd0, m_level});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 32'd0);
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        rden = 1'b1;
        #1;
        check(tag, dout, exp);
        rden = 1'b0;
    endtask

    task automatic read_all(input string tag);
        read_check({tag, "_count"},  3'd0, m_left);
        read_check({tag, "_ctrl"},   3'd1, {30'd0, (m_en && m_left != 0), m_en});
        read_check({tag, "_period"}, 3'd2, m_period);
        read_check({tag, "_total"},  3'd3, m_total);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wren  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        prev_pulse = pulse_out;
        edges = 0;
    endtask

    initial begin
        logic [31:0] v;
        logic        lvl;
        int          base_total;
        reset = 1'b1; rden = 1'b0; din = 32'd0; addr = 3'd0; wren = 1'b0;
        edges = 0; prev_pulse = 1'b0;

        // 1. reset values
        do_reset();
        read_check("rst_count",  3'd0, 32'd0);
        read_check("rst_ctrl",   3'd1, 32'd1);
        read_check("rst_period", 3'd2, 32'd4);
        read_check("rst_total",  3'd3, 32'd0);
        read_check("rst_addr5",  3'd5, 32'd0);
        check("rst_pulse", {31'd0, pulse_out}, 32'd0);
        addr = 3'd2; rden = 1'b0; #1;
        check("rden0_dout", dout, 32'd0);

        // 2. PERIOD=4, COUNT=3: edges at T+4, T+8, T+12
        tick(1'b1, 3'd2, 32'd4);
        tick(1'b1, 3'd0, 32'd3);
        idle(3);
        check("t2_no_edge_yet", {31'd0, pulse_out}, 32'd0);
        idle(1);
        check("t2_first_edge", {31'd0, pulse_out}, 32'd1);
        idle(7);
        read_check("t2_busy_before_last", 3'd1, 32'd3);
        idle(1);
        check("t2_final_level", {31'd0, pulse_out}, 32'd1);
        read_check("t2_idle_ctrl", 3'd1, 32'd1);
        read_check("t2_count", 3'd0, 32'd0);
        read_check("t2_total", 3'd3, 32'd3);

        // 3. PERIOD=0 acts as 1: an edge every clock
        do_reset();
        tick(1'b1, 3'd2, 32'd0);
        tick(1'b1, 3'd0, 32'd5);
        idle(5);
        check("t3_edges", edges, 32'd5);
        check("t3_level", {31'd0, pulse_out}, 32'd1);
        read_check("t3_total", 3'd3, 32'd5);

        // 4. pause mid-burst; no edge lost or added
        do_reset();
        tick(1'b1, 3'd2, 32'd10);
        tick(1'b1, 3'd0, 32'd4);
        idle(14);
        tick(1'b1, 3'd1, 32'd0);
        lvl = pulse_out;
        idle(20);
        check("t4_frozen", {31'd0, pulse_out}, {31'd0, lvl});
        read_check("t4_count_held", 3'd0, 32'd3);
        tick(1'b1, 3'd1, 32'd1);
        idle(4);
        check("t4_resume_wait", {31'd0, pulse_out}, {31'd0, lvl});
        idle(1);
        check("t4_resume_edge", {31'd0, pulse_out}, {31'd0, ~lvl});
        idle(25);
        check("t4_edges", edges, 32'd4);
        read_check("t4_total", 3'd3, 32'd4);

        // 5. COUNT write on the due cycle wins over the edge
        do_reset();
        tick(1'b1, 3'd2, 32'd8);
        tick(1'b1, 3'd0, 32'd2);
        idle(7);
        tick(1'b1, 3'd0, 32'd1);
        check("t5_suppressed", edges, 32'd0);
        idle(7);
        check("t5_before", edges, 32'd0);
        idle(1);
        check("t5_one_edge", edges, 32'd1);
        idle(10);
        check("t5_idle", edges, 32'd1);
        read_check("t5_ctrl", 3'd1, 32'd1);

        // TOTAL clear in an edge cycle, reset mid-burst, long burst
        do_reset();
        tick(1'b1, 3'd2, 32'd2);
        tick(1'b1, 3'd0, 32'd3);
        idle(1);
        tick(1'b1, 3'd3, 32'hDEAD_BEEF);
        read_check("tot_clear_on_edge", 3'd3, 32'd0);
        idle(3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        prev_pulse = pulse_out;
        check("midrst_pulse", {31'd0, pulse_out}, 32'd0);
        read_all("midrst");
        tick(1'b1, 3'd0, 32'hFFFF_FFFF);
        idle(4);
        read_check("long_count", 3'd0, 32'hFFFF_FFFE);
        tick(1'b1, 3'd0, 32'd0);
        idle(6);
        read_all("abort");

        // randomized traffic against the model
        do_reset();
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1: tick(1'b1, 3'd0, $urandom_range(0, 5));
                2:    tick(1'b1, 3'd2, $urandom_range(0, 5));
                3:    tick(1'b1, 3'd1, {$urandom} & 32'hFFFF_FFFF);
                4:    tick(1'b1, 3'd3, $urandom);
                5:    tick(1'b1, 3'($urandom_range(4, 7)), $urandom);
                default: idle($urandom_range(1, 6));
            endcase
            if (it % 25 == 0) begin
                v = 32'($urandom_range(4, 7));
                read_check("rnd_unused", v[2:0], 32'd0);
                read_all("rnd");
            end
        end
        read_all("rnd_end");

        // 6. loopback into an edge counter
        do_reset();
        base_total = 0;
        tick(1'b1, 3'd2, 32'd3);
        tick(1'b1, 3'd0, 32'd100);
        idle(310);
        check("loop_edges", edges, 32'd100 + base_total);
        read_check("loop_total", 3'd3, 32'd100);
        read_check("loop_count", 3'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
